// File: rtl/dsp_fir_mac_seq.sv
// ----------------------------------------------------------------------------
// dsp_fir_mac_seq
//   Time-multiplexed FIR filter for the audio path. Each channel has one
//   multiply-accumulate lane that processes one tap per clock. All channels
//   of a frame are filtered in parallel and share one runtime-loadable
//   coefficient set. The result is rounded half toward +inf and saturated.
//
//   Optional build macro: DSP_FIR_SYMMETRIC_EN
//     When defined, the filter uses linear-phase folding. Only ceil(TAPS/2)
//     coefficients are stored, and each MAC step uses the pre-added pair
//     x[n-k] + x[n-TAPS+1+k]. For odd TAPS the centre tap is used unpaired.
//     When undefined, all TAPS coefficients are stored and MAC takes TAPS cycles.
//
// Ports
//   iCLK, iRST   clock; synchronous active-high reset
//   iIn/iValid   input frame (channel c at [c*WS +: WS]); accepted in IDLE
//   oReady       high in IDLE, except during a reset cycle
//   oOut/oValid  filtered frame; oOut holds its value, oValid pulses once
//   oSat         per-channel clip flag, valid together with oValid
//   iCoefWe/iCoefAddr/iCoefData  coefficient write port (IDLE only)
//   oErr         sticky: [0] frame overrun, [1] dropped coefficient write
// ----------------------------------------------------------------------------

// One channel: accumulator, rounding, saturation and the output register.
module dsp_fir_mac_lane #(
    parameter int XW = 16,
    parameter int CW = 16,
    parameter int WS = 16,
    parameter int DP = 14,
    parameter int AW = 37
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iClr,
    input  logic                 iMac,
    input  logic                 iRound,
    input  logic signed [XW-1:0] iX,
    input  logic signed [CW-1:0] iC,
    output logic signed [WS-1:0] oY,
    output logic                 oSat
);
    localparam logic signed [AW:0] HALF = ((AW+1)'(1) <<< DP) >>> 1;
    localparam logic signed [AW:0] YMAX = ((AW+1)'(1) <<< (WS-1)) - (AW+1)'(1);
    localparam logic signed [AW:0] YMIN = -YMAX - (AW+1)'(1);

    logic signed [AW-1:0]    acc;
    logic signed [XW+CW-1:0] prod;
    logic signed [AW:0]      rnd;
    logic signed [AW:0]      y;

    assign prod = iX * iC;
    // One guard bit keeps the rounding add from wrapping near full scale.
    assign rnd  = (AW+1)'(acc) + HALF;
    assign y    = rnd >>> DP;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc  <= '0;
            oY   <= '0;
            oSat <= 1'b0;
        end else begin
            if (iClr)
                acc <= '0;
            else if (iMac)
                acc <= acc + AW'(prod);
            if (iRound) begin
                if (y > YMAX) begin
                    oY   <= WS'(YMAX);
                    oSat <= 1'b1;
                end else if (y < YMIN) begin
                    oY   <= WS'(YMIN);
                    oSat <= 1'b1;
                end else begin
                    oY   <= WS'(y);
                    oSat <= 1'b0;
                end
            end
        end
    end
endmodule

module dsp_fir_mac_seq #(
    parameter int WS   = 16,
    parameter int CW   = 16,
    parameter int TAPS = 32,
    parameter int CH   = 2,
    parameter int DP   = 14,
    parameter int AW   = WS + CW + $clog2(TAPS)
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [CH*WS-1:0]         iIn,
    input  logic                     iValid,
    output logic                     oReady,
    output logic [CH*WS-1:0]         oOut,
    output logic                     oValid,
    output logic [CH-1:0]            oSat,
    input  logic                     iCoefWe,
    input  logic [$clog2(TAPS)-1:0]  iCoefAddr,
    input  logic [CW-1:0]            iCoefData,
    output logic [1:0]               oErr
);
    localparam int AD = $clog2(TAPS);
`ifdef DSP_FIR_SYMMETRIC_EN
    localparam int NC = (TAPS + 1) / 2;
    localparam int XW = WS + 1;
`else
    localparam int NC = TAPS;
    localparam int XW = WS;
`endif
    localparam logic [AD:0]   TAPS_E = (AD+1)'(TAPS);
    localparam logic [AD:0]   NC_E   = (AD+1)'(NC);
    localparam logic [AD-1:0] KLAST  = AD'(NC - 1);
    localparam logic [AD-1:0] WPLAST = AD'(TAPS - 1);
    localparam logic [CW-1:0] UNITY  = CW'(1) << DP;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MAC   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;

    logic [1:0]               state;
    logic [AD-1:0]            k;
    logic [AD-1:0]            wp;
    logic [CH-1:0][WS-1:0]    hist [TAPS];
    logic signed [CW-1:0]     coef [NC];
    logic                     accept;
    logic                     kLast;
    logic                     coefOk;
    logic [AD:0]              rdE;
    logic [AD-1:0]            rdPtr;

    assign accept = (state == IDLE) && iValid;
    assign oReady = (state == IDLE) && !iRST;
    assign kLast  = (k == KLAST);
    assign coefOk = (state == IDLE) && ({1'b0, iCoefAddr} < NC_E);

    // x[n-k] lives at (wp-k) mod TAPS. TAPS need not be a power of two, so the
    // wrap is explicit.
    always_comb begin
        if ({1'b0, wp} >= {1'b0, k})
            rdE = {1'b0, wp} - {1'b0, k};
        else
            rdE = {1'b0, wp} + TAPS_E - {1'b0, k};
        rdPtr = rdE[AD-1:0];
    end

`ifdef DSP_FIR_SYMMETRIC_EN
    // The mirror sample x[n-TAPS+1+k] lives at (wp+1+k) mod TAPS.
    logic [AD:0]   rd2E;
    logic [AD-1:0] rdPtr2;
    logic          centre;
    always_comb begin
        rd2E = {1'b0, wp} + {1'b0, k} + (AD+1)'(1);
        if (rd2E >= TAPS_E)
            rd2E = rd2E - TAPS_E;
        rdPtr2 = rd2E[AD-1:0];
    end
    assign centre = ((TAPS % 2) == 1) && kLast;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state  <= IDLE;
            k      <= '0;
            wp     <= '0;
            oValid <= 1'b0;
            oErr   <= '0;
            for (int i = 0; i < TAPS; i++)
                hist[i] <= '0;
            for (int i = 0; i < NC; i++)
                coef[i] <= '0;
            coef[0] <= UNITY;
        end else begin
            oValid <= 1'b0;
            if (iValid && state != IDLE)
                oErr[0] <= 1'b1;
            // A write in the accepting cycle lands before MAC starts, so it
            // applies to that frame.
            if (iCoefWe) begin
                if (coefOk)
                    coef[iCoefAddr] <= iCoefData;
                else
                    oErr[1] <= 1'b1;
            end
            case (state)
                IDLE: if (iValid) begin
                    hist[wp] <= iIn;
                    k        <= '0;
                    state    <= MAC;
                end
                MAC: begin
                    k <= kLast ? '0 : k + 1'b1;
                    if (kLast)
                        state <= ROUND;
                end
                ROUND: begin
                    oValid <= 1'b1;
                    wp     <= (wp == WPLAST) ? '0 : wp + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CH; c++) begin : gLane
        logic signed [WS-1:0] xa;
        logic signed [XW-1:0] opX;
        logic signed [WS-1:0] laneY;
        assign xa = hist[rdPtr][c];
`ifdef DSP_FIR_SYMMETRIC_EN
        logic signed [WS-1:0] xb;
        assign xb  = hist[rdPtr2][c];
        assign opX = centre ? XW'(xa) : XW'(xa) + XW'(xb);
`else
        assign opX = xa;
`endif
        dsp_fir_mac_lane #(
            .XW(XW), .CW(CW), .WS(WS), .DP(DP), .AW(AW)
        ) uLane (
            .iCLK   (iCLK),
            .iRST   (iRST),
            .iClr   (accept),
            .iMac   (state == MAC),
            .iRound (state == ROUND),
            .iX     (opX),
            .iC     (coef[k]),
            .oY     (laneY),
            .oSat   (oSat[c])
        );
        assign oOut[c*WS +: WS] = laneY;
    end
endmodule

// File: tb/tb_dsp_fir_mac_seq.sv
// ----------------------------------------------------------------------------
// tb_dsp_fir_mac_seq
//   Directed bench for dsp_fir_mac_seq in the default (non-folded) build.
//   TAPS=6 is used so that an address of TAPS fits in the address port.
//   Stimulus pushes the hand-computed result and the due cycle into a
//   scoreboard. A monitor compares each oValid pulse against that scoreboard.
// ----------------------------------------------------------------------------
module tb_dsp_fir_mac_seq;
    localparam int WS   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 6;
    localparam int CH   = 2;
    localparam int DP   = 14;
    localparam int AD   = $clog2(TAPS);

    logic               iCLK = 1'b0;
    logic               iRST;
    logic [CH*WS-1:0]   iIn;
    logic               iValid;
    logic               oReady;
    logic [CH*WS-1:0]   oOut;
    logic               oValid;
    logic [CH-1:0]      oSat;
    logic               iCoefWe;
    logic [AD-1:0]      iCoefAddr;
    logic [CW-1:0]      iCoefData;
    logic [1:0]         oErr;

    dsp_fir_mac_seq #(.WS(WS), .CW(CW), .TAPS(TAPS), .CH(CH), .DP(DP)) dut (
        .iCLK(iCLK), .iRST(iRST), .iIn(iIn), .iValid(iValid), .oReady(oReady),
        .oOut(oOut), .oValid(oValid), .oSat(oSat), .iCoefWe(iCoefWe),
        .iCoefAddr(iCoefAddr), .iCoefData(iCoefData), .oErr(oErr)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct { int y0; int y1; int sat; int due; } exp_t;
    exp_t sb[$];
    exp_t e;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every oValid pulse must match the oldest expected frame.
    always @(negedge iCLK) begin
        if (oValid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_oValid: got oOut=%h expected no output", oOut);
            end else begin
                e = sb.pop_front();
                check("ch0", int'($signed(oOut[WS-1:0])), e.y0);
                check("ch1", int'($signed(oOut[2*WS-1:WS])), e.y1);
                check("oSat", int'(oSat), e.sat);
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (oReady !== 1'b1 && n < 200) begin
            @(negedge iCLK);
            n++;
        end
        if (oReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got oReady=%b expected 1", oReady);
        end
    endtask

    // Issue one frame. It is accepted on the next edge, and oValid is due
    // TAPS+1 edges after that.
    task automatic send(input int x0, input int x1, input int y0, input int y1, input int sat);
        exp_t t;
        waitReady();
        iIn    = {WS'(x1), WS'(x0)};
        iValid = 1'b1;
        t.y0 = y0; t.y1 = y1; t.sat = sat; t.due = cyc + 1 + TAPS + 1;
        sb.push_back(t);
        @(negedge iCLK);
        iValid = 1'b0;
    endtask

    task automatic wcoef(input int a, input int d);
        waitReady();
        iCoefWe   = 1'b1;
        iCoefAddr = AD'(a);
        iCoefData = CW'(d);
        @(negedge iCLK);
        iCoefWe = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge iCLK);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(negedge iCLK);
    endtask

    task automatic doReset();
        iRST    = 1'b1;
        iValid  = 1'b0;
        iCoefWe = 1'b0;
        #1;
        check("oReady_in_reset", int'(oReady), 0);
        @(negedge iCLK);
        iRST = 1'b0;
        check("rst_oOut", int'(oOut), 0);
        check("rst_oValid", int'(oValid), 0);
        check("rst_oSat", int'(oSat), 0);
        check("rst_oErr", int'(oErr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1'b1; iValid = 1'b0; iIn = '0;
        iCoefWe = 1'b0; iCoefAddr = '0; iCoefData = '0;

        // 1: identity after reset
        doReset();
        send(1000, -1234, 1000, -1234, 0);
        drain();

        // 2: 4-tap moving average of a step
        doReset();
        for (int i = 0; i < 4; i++) wcoef(i, 4096);
        send(8000, -8000, 2000, -2000, 0);
        send(8000, -8000, 4000, -4000, 0);
        send(8000, -8000, 6000, -6000, 0);
        send(8000, -8000, 8000, -8000, 0);
        send(8000, -8000, 8000, -8000, 0);
        drain();

        // 3: rounding half toward +inf, then saturation both ways
        doReset();
        wcoef(0, 8192);
        send(3, -3, 2, -1, 0);
        drain();
        doReset();
        wcoef(1, 16384);
        send(30000, -30000, 30000, -30000, 0);
        send(30000, -30000, 32767, -32768, 3);
        send(-30000, 30000, 0, 0, 0);
        send(-30000, 30000, -32768, 32767, 3);
        drain();

        // 4: impulse through the last tap exercises the history wrap
        doReset();
        wcoef(0, 0);
        wcoef(TAPS-1, 16384);
        for (int i = 0; i < TAPS + 4; i++)
            send(i == 0 ? 500 : 0, i == 0 ? -500 : 0,
                 i == TAPS-1 ? 500 : 0, i == TAPS-1 ? -500 : 0, 0);
        drain();

        // 5: overrun and illegal coefficient writes
        doReset();
        wcoef(0, 8192);
        wcoef(1, 8192);
        send(100, -100, 50, -50, 0);
        iIn = {WS'(999), WS'(999)};
        iValid = 1'b1;
        @(negedge iCLK);
        iValid = 1'b0;
        check("err_overrun", int'(oErr), 1);
        send(300, -300, 200, -200, 0);
        iCoefWe = 1'b1; iCoefAddr = AD'(1); iCoefData = '0;
        @(negedge iCLK);
        iCoefWe = 1'b0;
        check("err_coef_busy", int'(oErr), 3);
        send(500, -500, 400, -400, 0);
        drain();
        doReset();
        wcoef(TAPS, 1234);
        check("err_coef_addr", int'(oErr), 2);
        send(700, -700, 700, -700, 0);
        drain();

        // 6: reset in the middle of MAC discards the frame
        doReset();
        wcoef(0, 8192);
        waitReady();
        iIn = {WS'(-1234), WS'(1234)};
        iValid = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        iValid = 1'b0;
        check("err_before_reset", int'(oErr), 1);
        repeat (3) @(negedge iCLK);
        doReset();
        repeat (TAPS + 4) @(negedge iCLK);
        send(777, -777, 777, -777, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
